// File: rtl/load_pkg.sv
// Shared definitions for the RV32 load unit: funct3 encodings, FSM states, exception causes
// and small helpers that classify a load by type and byte offset.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] EXC_MISALIGN = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StWait0,
    StReq1,
    StWait1,
    StResp,
    StExc
  } load_state_e;

  function automatic logic load_legal(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

  // True when the accessed bytes straddle two memory words.
  function automatic logic load_crosses(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off == 2'b11;
      F3_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational byte alignment and sign/zero extension of a load result taken from
// the two-word window {w1, w0} starting at byte offset byte_off.
module load_align_ext
  import load_pkg::*;
(
  input  logic [31:0] w1,
  input  logic [31:0] w0,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'({w1, w0} >> {byte_off, 3'b000});
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {24'h000000, shifted[7:0]};
      F3_LHU:  result = {16'h0000, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Sequential RV32 integer load unit: computes the effective address, issues one or two
// word-aligned reads, then returns an extended write-back pulse or an exception pulse.
module load_unit
  import load_pkg::*;
#(
  parameter int unsigned ADDR_W             = 32,
  parameter bit          SUPPORT_MISALIGNED = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [11:0]       req_offset,
  input  logic [2:0]        req_funct3,
  input  logic [4:0]        req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr,
  output logic              busy
);

  localparam bit          TimeoutEn   = TIMEOUT_CYCLES != 0;
  localparam logic [31:0] TimeoutLast = TimeoutEn ? TIMEOUT_CYCLES - 1 : 32'd0;

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       w0_q, w0_d, w1_q, w1_d;
  logic [31:0]       wait_cnt_q, wait_cnt_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [1:0]        exc_cause_q, exc_cause_d;
  logic [ADDR_W-1:0] exc_addr_q, exc_addr_d;

  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       w0_in, w1_in, ext_result;
  logic              timeout_hit;

  assign eff_addr    = req_src1 + {{(ADDR_W-12){req_offset[11]}}, req_offset};
  assign word_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign timeout_hit = TimeoutEn && (wait_cnt_q == TimeoutLast);

  // Feed the arriving word straight into the extractor so the result is ready on RESP entry.
  assign w0_in = (state_q == StWait0) ? mem_rsp_data : w0_q;
  assign w1_in = (state_q == StWait1) ? mem_rsp_data : w1_q;

  load_align_ext u_align (
    .w1       (w1_in),
    .w0       (w0_in),
    .byte_off (addr_q[1:0]),
    .funct3   (funct3_q),
    .result   (ext_result)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    wait_cnt_d  = wait_cnt_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d   = eff_addr;
          funct3_d = req_funct3;
          wb_rd_d  = req_rd;
          if (!load_legal(req_funct3)) begin
            state_d     = StExc;
            exc_cause_d = EXC_ILLEGAL;
            exc_addr_d  = eff_addr;
          end else if (!SUPPORT_MISALIGNED && load_misaligned(req_funct3, eff_addr[1:0])) begin
            state_d     = StExc;
            exc_cause_d = EXC_MISALIGN;
            exc_addr_d  = eff_addr;
          end else begin
            state_d = StReq0;
          end
        end
      end
      StReq0: begin
        if (mem_req_ready) begin
          state_d    = StWait0;
          wait_cnt_d = '0;
        end
      end
      StWait0: begin
        if (mem_rsp_valid) begin
          w0_d = mem_rsp_data;
          if (load_crosses(funct3_q, addr_q[1:0])) begin
            state_d = StReq1;
          end else begin
            state_d   = StResp;
            wb_data_d = ext_result;
          end
        end else if (timeout_hit) begin
          state_d     = StExc;
          exc_cause_d = EXC_TIMEOUT;
          exc_addr_d  = addr_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StReq1: begin
        if (mem_req_ready) begin
          state_d    = StWait1;
          wait_cnt_d = '0;
        end
      end
      StWait1: begin
        if (mem_rsp_valid) begin
          w1_d      = mem_rsp_data;
          state_d   = StResp;
          wb_data_d = ext_result;
        end else if (timeout_hit) begin
          state_d     = StExc;
          exc_cause_d = EXC_TIMEOUT;
          exc_addr_d  = addr_q;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      StResp:  state_d = StIdle;
      StExc:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      funct3_q    <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      wait_cnt_q  <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      wait_cnt_q  <= wait_cnt_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign busy          = state_q != StIdle;
  assign req_ready     = state_q == StIdle;
  assign mem_req_valid = (state_q == StReq0) || (state_q == StReq1);
  assign mem_req_addr  = (state_q == StReq1) ? word_addr + ADDR_W'(4) : word_addr;
  assign wb_valid      = state_q == StResp;
  assign exc_valid     = state_q == StExc;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign exc_cause     = exc_cause_q;
  assign exc_addr      = exc_addr_q;

endmodule
